keypad_entry: RTL and testbench
===============================

# keypad_entry

Scans a 4x4 matrix keypad and turns debounced key presses into hex digits. Each new digit is shifted into a 16-bit value, so the keypad feeds the same 4-digit seven-segment display path that renders `data`. This block is the input side of the display chain: it produces the `data[15:0]` word the display driver consumes.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled (≥2).
- `DEBOUNCE`, default 4: consecutive qualifying samples required to accept a press or a release (≥2).
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `row` input 4: keypad rows, active-low (pulled up externally).
- `clr` input 1: synchronous clear of `data`.
- `col` output 4: keypad column drive, active-low one-hot.
- `data` output 16: last four entered digits; the newest is in `[3:0]`.
- `key_code` output 4: code of the most recently accepted key.
- `key_valid` output 1: one-cycle pulse per accepted key.

## Operation
- **Key map**, hex codes by (row, col):
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: E (`*`), 0, F (`#`), D.
- **Scan divider:** counts 0..SCAN_DIV-1 continuously. The *sample point* is the cycle where the count equals SCAN_DIV-1.
- **Column drive:** `col = ~(1 << col_idx)`. `col_idx` advances (3 wraps to 0) only at a sample point in SCAN when no row is low, or on a return to SCAN.
- **FSM** (all transitions happen at sample points only):
  - **SCAN:** if any row is low, latch `col_idx` and the lowest-index low row, set the debounce count to 1, and go to DEB_PRESS. Otherwise advance the column.
  - **DEB_PRESS:** if the latched row is still low, increment the count. When the count reaches DEBOUNCE, accept the key and go to HELD. If the latched row is high, go to SCAN and advance the column; no output.
  - **HELD:** if the latched row is high, set the count to 1 and go to DEB_REL. There is no auto-repeat.
  - **DEB_REL:** if the latched row is high, increment the count; at DEBOUNCE go to SCAN and advance the column. If the latched row goes low again, go back to HELD.
- **Accept:** `key_code <= code`, `data <= {data[11:0], code}`, and `key_valid` is 1 for exactly that cycle.
- **Multiple rows low in SCAN:** the lowest row index wins. Other rows are ignored until the next return to SCAN.
- **`clr` timing:**
  - `clr` is honoured on any cycle: `data <= 16'h0000`.
  - If `clr` and accept fall on the same cycle, `data <= {12'h000, code}`.
  - `clr` does not affect the FSM, `key_code` or `key_valid`.
- **Reset values:** `col = 4'b1110`, `data = 16'h0000`, `key_code = 4'h0`, `key_valid = 0`, FSM in SCAN, all counters 0. Reset mid-debounce discards the pending key with no pulse.
- **Counter widths:** divider is `$clog2(SCAN_DIV)` bits; debounce count is `$clog2(DEBOUNCE+1)` bits. Neither counter wraps inside a state.

## Timing
- Rows are sampled in the same cycle as the sample point, so each column dwells a full SCAN_DIV cycles before sampling.
- Press latency, from the first sample that sees the key low to `key_valid`: (DEBOUNCE-1)·SCAN_DIV + 1 cycles.
- `key_valid`, `key_code` and `data` all update on the same clock edge.
- Minimum time between accepted keys: 2·DEBOUNCE sample periods.
- `col` changes only on the edge after a sample point.

## Configuration
- **`KEYPAD_SYNC_EN` defined:** `row` passes through a two-flop synchronizer (reset to 4'b1111) before sampling. Every press and release latency grows by 2 cycles, and a column change takes 2 extra cycles to appear at the sampler. SCAN_DIV ≥ 4 is required in this mode.
- **`KEYPAD_SYNC_EN` undefined:** `row` is sampled directly. For use only with externally synchronized inputs.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE=3.

- **Reset:** hold `rst_n`=0 with keys pressed → `col`=4'b1110, `data`=16'h0000, `key_valid`=0. Release reset → `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- **Single press:** press "5" (row1 low while col1 low) for 200 cycles → exactly one `key_valid`, `key_code`=4'h5, `data`=16'h0005, arriving 9 cycles after first detection (+2 with `KEYPAD_SYNC_EN`).
- **Sequence:** enter 1, 2, 3, A, each with full release → `data`=16'h123A. Then enter 4 → `data`=16'h23A4.
- **Bounce rejection:**
  - Row low for 1 sample, then high → no `key_valid`, and scanning resumes at the next column.
  - Release glitch of 1 sample during HELD → no second pulse.
- **Clear:** `clr` alone → `data`=16'h0000. `clr` in the same cycle as accepting "#" → `data`=16'h000F, `key_valid`=1.
- **Reset mid-operation:** assert `rst_n` during DEB_PRESS of "7" → no pulse, all outputs return to reset values. Keep the key held after reset → it is accepted once.

Source files
------------

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: column drive, debounce FSM and 4-digit hex entry register.
// Optional two-flop row synchronizer enabled by defining KEYPAD_SYNC_EN.
module keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [15:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       lat_row, lat_row_n;
  logic [1:0]       low_idx;
  logic [3:0]       row_s;
  logic [3:0]       code;
  logic             sample, any_low, lat_low, accept;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_m, row_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'b1111;
      row_q <= 4'b1111;
    end else begin
      row_m <= row;
      row_q <= row_m;
    end
  end
  assign row_s = row_q;
`else
  assign row_s = row;
`endif

  assign sample = (div == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div <= '0;
    else if (sample) div <= '0;
    else             div <= div + 1'b1;
  end

  // Lowest-index low row wins when several rows are pulled down at once.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_s[i]) low_idx = 2'(i);
  end

  assign any_low = ~&row_s;
  assign lat_low = ~row_s[lat_row];
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      cnt     <= '0;
      col_idx <= 2'd0;
      lat_row <= 2'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col_idx <= col_idx_n;
      lat_row <= lat_row_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_idx_n = col_idx;
    lat_row_n = lat_row;
    accept    = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            lat_row_n = low_idx;
            cnt_n     = CNT_W'(1);
            state_n   = DEB_PRESS;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (lat_low) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_N) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            cnt_n     = '0;
            col_idx_n = col_idx + 2'd1;
            state_n   = SCAN;
          end
        end
        HELD: begin
          if (!lat_low) begin
            cnt_n   = CNT_W'(1);
            state_n = DEB_REL;
          end
        end
        DEB_REL: begin
          if (!lat_low) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_N) begin
              cnt_n     = '0;
              col_idx_n = col_idx + 2'd1;
              state_n   = SCAN;
            end
          end else begin
            cnt_n   = '0;
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'hE;
      4'b11_01: key_map = 4'h0;
      4'b11_10: key_map = 4'hF;
      default:  key_map = 4'hD;
    endcase
  endfunction

  // col_idx is frozen outside SCAN, so it serves as the latched column.
  assign code = key_map(lat_row, col_idx);
  assign col  = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      data      <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= code;
      if (clr && accept) data <= {12'h000, code};
      else if (clr)      data <= 16'h0000;
      else if (accept)   data <= {data[11:0], code};
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: behavioural keypad, scoreboard of expected accepts.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [15:0] data;
  logic [3:0]  key_code;
  logic        key_valid;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          pulses = 0;
  int          pulse_cyc = 0;
  logic        key_on = 1'b0;
  logic [1:0]  key_r  = 2'd0;
  logic [1:0]  key_c  = 2'd0;
  logic [15:0] model_data = 16'h0000;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .clr(clr),
    .col(col), .data(data), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Single-key matrix: the pressed row is pulled low while its column is driven.
  always_comb begin
    row = 4'b1111;
    if (key_on && !col[key_c]) row[key_r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (key_valid === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(key_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("key_code", 32'(key_code), 32'(e.code));
        check("data_at_accept", 32'(data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] x, input string tag);
    for (int i = 0; i < 40 && col !== x; i++) tick();
    check(tag, 32'(col), 32'(x));
  endtask

  task automatic wait_pulse(input string tag);
    int start;
    start = pulses;
    for (int i = 0; i < 100 && pulses == start; i++) tick();
    check(tag, pulses, start + 1);
  endtask

  task automatic push(input logic [3:0] code, input logic do_clr);
    exp_t e;
    model_data = do_clr ? {12'h000, code} : {model_data[11:0], code};
    e.code = code;
    e.data = model_data;
    sb.push_back(e);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  task automatic enter(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
    push(code, 1'b0);
    press(r, c);
    wait_pulse("enter_pulse");
    repeat (10) tick();
    key_on = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    logic [3:0] step_seq [0:3];
    logic [3:0] cur;
    int         base, e_cyc;
    step_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset held with a key down
    rst_n = 1'b0;
    clr   = 1'b0;
    press(2'd0, 2'd0);
    repeat (5) tick();
    check("rst_col", 32'(col), 32'h0000000E);
    check("rst_data", 32'(data), 32'h0);
    check("rst_kv", 32'(key_valid), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    key_on = 1'b0;
    tick();
    rst_n = 1'b1;

    // Column stepping every SCAN_DIV cycles
    wait_col(step_seq[0], "step_first");
    cur = step_seq[0];
    for (int k = 1; k < 4; k++) begin
      repeat (3) begin
        tick();
        check("col_hold", 32'(col), 32'(cur));
      end
      tick();
      check("col_step", 32'(col), 32'(step_seq[k]));
      cur = step_seq[k];
    end

    // Single press "5", latency counted from the column change
    base = pulses;
    push(4'h5, 1'b0);
    press(2'd1, 2'd1);
    wait_col(4'b1101, "col_for_5");
    e_cyc = cyc;
    wait_pulse("pulse_5");
    check("latency_5", pulse_cyc - e_cyc, 12);
    repeat (200) tick();
    key_on = 1'b0;
    repeat (30) tick();
    check("single_pulse_5", pulses, base + 1);
    check("data_5", 32'(data), 32'h0005);

    // Sequence 1 2 3 A then 4
    enter(2'd0, 2'd0, 4'h1);
    enter(2'd0, 2'd1, 4'h2);
    enter(2'd0, 2'd2, 4'h3);
    enter(2'd0, 2'd3, 4'hA);
    check("data_123A", 32'(data), 32'h123A);
    enter(2'd1, 2'd0, 4'h4);
    check("data_23A4", 32'(data), 32'h23A4);

    // One-sample press of "9" is rejected and scanning resumes at the next column
    base = pulses;
    wait_col(4'b1011, "col_for_9");
    press(2'd2, 2'd2);
    repeat (4) tick();
    key_on = 1'b0;
    check("bounce_hold", 32'(col), 32'h0000000B);
    repeat (3) begin
      tick();
      check("bounce_hold", 32'(col), 32'h0000000B);
    end
    tick();
    check("bounce_next_col", 32'(col), 32'h00000007);
    repeat (20) tick();
    check("bounce_no_pulse", pulses, base);

    // Release glitch of one sample during HELD on "6"
    base = pulses;
    push(4'h6, 1'b0);
    press(2'd1, 2'd2);
    wait_pulse("pulse_6");
    repeat (2) tick();
    key_on = 1'b0;
    repeat (4) tick();
    key_on = 1'b1;
    repeat (20) tick();
    key_on = 1'b0;
    repeat (30) tick();
    check("glitch_one_pulse", pulses, base + 1);

    // Clear alone
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_data = 16'h0000;
    tick();
    check("clr_alone", 32'(data), 32'h0);
    enter(2'd2, 2'd0, 4'h7);
    check("data_7", 32'(data), 32'h0007);

    // Clear coinciding with accept of "#"
    base = pulses;
    wait_col(4'b1101, "col_pre_hash");
    press(2'd3, 2'd2);
    push(4'hF, 1'b1);
    wait_col(4'b1011, "col_for_hash");
    repeat (11) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("hash_pulse", pulses, base + 1);
    repeat (10) tick();
    check("data_clr_hash", 32'(data), 32'h000F);
    key_on = 1'b0;
    repeat (30) tick();

    // Reset during DEB_PRESS of "7", key kept down through reset
    base = pulses;
    wait_col(4'b0111, "col_pre_7");
    press(2'd2, 2'd0);
    wait_col(4'b1110, "col_for_7");
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'h0000000E);
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_kv", 32'(key_valid), 32'h0);
    model_data = 16'h0000;
    repeat (3) tick();
    check("mid_rst_no_pulse", pulses, base);
    push(4'h7, 1'b0);
    rst_n = 1'b1;
    wait_pulse("pulse_7_after_rst");
    repeat (30) tick();
    check("held_7_once", pulses, base + 1);
    key_on = 1'b0;
    repeat (30) tick();

    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
